prog_div_counter: RTL

//   Parametrised two-stage (prescaler + main) programmable cycle counter.

---
 rtl/prog_div_counter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/prog_div_counter.sv
// Two-stage (prescaler + main) programmable cycle counter with one-shot/periodic modes.
// Optional sticky done flag (o_irq, i_irq_clr) when PCNT_IRQ_EN is defined.
//   state | meaning
//   IDLE  | stopped, waiting for i_start
//   RUN   | prescaler/main counter advancing while i_ena is high
//   DONE  | o_done asserted for DONE_LEN cycles
module prog_div_counter #(
    parameter int PRE_W    = 4,
    parameter int CNT_W    = 8,
    parameter int DONE_LEN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [PRE_W-1:0] i_pre_tc,
    input  logic [CNT_W-1:0] i_cnt_tc,
`ifdef PCNT_IRQ_EN
    input  logic             i_irq_clr,
    output logic             o_irq,
`endif
    output logic             o_tick,
    output logic [CNT_W-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    localparam int DL_W = (DONE_LEN > 1) ? $clog2(DONE_LEN) : 1;
    localparam logic [DL_W-1:0] DL_LAST = DL_W'(DONE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    logic [DL_W-1:0]  dcnt;
    logic             mode_q;
    logic [PRE_W-1:0] pre_tc_q;
    logic [CNT_W-1:0] cnt_tc_q;

    logic pre_wrap;
    logic cnt_last;
    logic dcnt_last;

    assign pre_wrap  = (pre == pre_tc_q);
    assign cnt_last  = (cnt == cnt_tc_q);
    assign dcnt_last = (dcnt == DL_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_start) begin
            state_nxt = RUN;
        end else if (i_stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (i_ena && pre_wrap && cnt_last) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (dcnt_last) begin
                        state_nxt = mode_q ? IDLE : RUN;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        o_busy  = (state != IDLE);
        o_done  = (state == DONE);
        o_tick  = (state == RUN) && i_ena && pre_wrap;
        o_count = cnt;
    end

    // Counters and shadow registers; shadows only load on i_start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre      <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            mode_q   <= 1'b0;
            pre_tc_q <= '0;
            cnt_tc_q <= '0;
        end else if (i_start) begin
            pre      <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            mode_q   <= i_mode;
            pre_tc_q <= i_pre_tc;
            cnt_tc_q <= i_cnt_tc;
        end else if (i_stop) begin
            pre  <= '0;
            cnt  <= '0;
            dcnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (i_ena) begin
                        if (pre_wrap) begin
                            pre <= '0;
                            if (cnt_last) begin
                                dcnt <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (dcnt_last) begin
                        dcnt <= '0;
                        // One-shot leaves cnt at the terminal value for readback.
                        if (!mode_q) begin
                            pre <= '0;
                            cnt <= '0;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    dcnt <= '0;
                end
            endcase
        end
    end

`ifdef PCNT_IRQ_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else if ((state == RUN) && (state_nxt == DONE)) begin
            o_irq <= 1'b1;
        end else if (i_irq_clr) begin
            o_irq <= 1'b0;
        end
    end
`endif

endmodule
